// File: rtl/picomips_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : picomips_pkg                                                 |
// | Purpose  : Shared types and constants for the picoMIPS datapath blocks. |
// | Revision : 1.0 - initial release                                        |
// ---------------------------------------------------------------------------
package picomips_pkg;

  // Default data / register-file width in bits
  localparam int MUL_WIDTH = 8;

  // Sequential multiplier control states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_e;

endpackage : picomips_pkg
`default_nettype wire

// File: rtl/mul_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : mul_seq                                                      |
// | Purpose  : Radix-2 shift-add signed multiplier, n cycles per operation, |
// |            full 2n-bit product plus saturated Q1.(n-1) fraction.        |
// | Revision : 1.0 - initial release                                        |
// ---------------------------------------------------------------------------
module mul_seq
  import picomips_pkg::*;
#(
  parameter int n = MUL_WIDTH
) (
  input  logic           clk,
  input  logic           nReset,
  input  logic           start,
  input  logic [n-1:0]   a,
  input  logic [n-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*n-1:0] prod,
  output logic [n-1:0]   result
);

  localparam int              CW        = $clog2(n + 1);
  localparam logic [CW-1:0]   LAST_STEP = CW'(n - 1);
  // Only -2^(n-1) * -2^(n-1) reaches this value; its fraction would wrap to -1
  localparam logic [2*n-1:0]  SAT_PROD  = {2'b01, {(2*n-2){1'b0}}};
  localparam logic [n-1:0]    RES_MAX   = {1'b0, {(n-1){1'b1}}};

  mul_state_e     state_q;
  logic [CW-1:0]  cnt_q;
  logic [n-1:0]   mcand_q;
  logic [n-1:0]   mplier_q;
  logic [2*n-1:0] acc_q;
  logic [2*n-1:0] prod_q;
  logic [n-1:0]   result_q;
  logic           busy_q;
  logic           done_q;

  logic           last_step;
  logic [2*n-1:0] pp;
  logic [2*n-1:0] acc_d;
  logic [n-1:0]   result_d;

  // Partial product for the current step, accumulator update and saturation stage
  always_comb begin
    last_step = (state_q == RUN) && (cnt_q == LAST_STEP);
    pp        = '0;
    if (mplier_q[0]) begin
      pp = {{n{mcand_q[n-1]}}, mcand_q} << cnt_q;
    end
    // The multiplier MSB carries weight -2^(n-1), so its partial product is subtracted
    acc_d    = last_step ? (acc_q - pp) : (acc_q + pp);
    result_d = (acc_d == SAT_PROD) ? RES_MAX : acc_d[2*n-2:n-1];
  end

  // Control FSM, operand capture, shift-add iteration and output registers
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      prod_q   <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          busy_q <= 1'b0;
          if (start) begin
            state_q  <= RUN;
            busy_q   <= 1'b1;
            mcand_q  <= a;
            mplier_q <= b;
            acc_q    <= '0;
            cnt_q    <= '0;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          acc_q    <= acc_d;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CW'(1);
          if (last_step) begin
            state_q  <= DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            prod_q   <= acc_d;
            result_q <= result_d;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign prod   = prod_q;
  assign result = result_q;

endmodule : mul_seq
`default_nettype wire

// File: tb/tb_mul_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : tb_mul_seq                                                   |
// | Purpose  : Self-checking bench for mul_seq (n = 8).                     |
// | Revision : 1.0 - initial release                                        |
// ---------------------------------------------------------------------------
module tb_mul_seq;

  localparam int N = 8;

  logic           clk;
  logic           nReset;
  logic           start;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*N-1:0] prod;
  logic [N-1:0]   result;

  int n_checks = 0;
  int n_fail   = 0;

  mul_seq #(.n(N)) dut (
    .clk    (clk),
    .nReset (nReset),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .prod   (prod),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an accepted operation completes n edges later with the
  // arithmetic product; the fraction is floor(p / 2^(n-1)) clipped to the max.
  int               m_remaining = 0;
  logic             m_done      = 1'b0;
  logic [2*N-1:0]   m_prod      = '0;
  logic [N-1:0]     m_result    = '0;
  logic signed [N-1:0] m_a = '0;
  logic signed [N-1:0] m_b = '0;

  always @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      m_remaining = 0;
      m_done      = 1'b0;
      m_prod      = '0;
      m_result    = '0;
    end else if (m_remaining > 0) begin
      m_remaining = m_remaining - 1;
      m_done      = 1'b0;
      if (m_remaining == 0) begin
        int pa, pb, p, r;
        pa = m_a;
        pb = m_b;
        p  = pa * pb;
        r  = p >>> (N - 1);
        if (r > (2 ** (N - 1)) - 1) r = (2 ** (N - 1)) - 1;
        m_prod   = p[2*N-1:0];
        m_result = r[N-1:0];
        m_done   = 1'b1;
      end
    end else begin
      m_done = 1'b0;
      if (start) begin
        m_a         = a;
        m_b         = b;
        m_remaining = N;
      end
    end
  end

  // Cycle-by-cycle comparison against the model once reset has first been applied
  initial begin
    @(negedge nReset);
    forever begin
      @(negedge clk);
      check("model_busy",   busy,   m_remaining > 0);
      check("model_done",   done,   m_done);
      check("model_prod",   prod,   m_prod);
      check("model_result", result, m_result);
    end
  end

  // One operation from a negedge: optional ignored re-pulses, operands scrambled after accept
  task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input bit repulse,
                        input logic [15:0] ep, input logic [7:0] er);
    int seen;
    int first;
    seen  = 0;
    first = 0;
    start = 1'b1;
    a     = ia;
    b     = ib;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin
        seen++;
        if (first == 0) first = i;
        check("lit_prod",   prod,   ep);
        check("lit_result", result, er);
      end
      start = repulse && (i == 2 || i == 5);
      a     = ia ^ 8'h5A ^ 8'(i);
      b     = ~ib ^ 8'(i);
    end
    check("done_latency", first, 9);
    check("done_count",   seen,  1);
  endtask

  logic [7:0]  ta [27];
  logic [7:0]  tb_b [27];
  logic [15:0] s_ep [3];
  logic [7:0]  s_er [3];

  initial begin
    int ndone;
    nReset = 1'b1;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    #2 nReset = 1'b0;
    #1;
    check("rst_busy",   busy,   0);
    check("rst_done",   done,   0);
    check("rst_prod",   prod,   0);
    check("rst_result", result, 0);
    repeat (2) @(negedge clk);

    // Release and start on the very first edge after release
    nReset = 1'b1;
    run_op(8'h40, 8'h40, 1'b0, 16'h1000, 8'h20);
    run_op(8'h80, 8'h80, 1'b0, 16'h4000, 8'h7F);
    run_op(8'h60, 8'hC0, 1'b0, 16'hE800, 8'hD0);
    run_op(8'h00, 8'h7F, 1'b0, 16'h0000, 8'h00);
    run_op(8'h7F, 8'h00, 1'b0, 16'h0000, 8'h00);
    // Re-pulsed start during RUN must be ignored: 37 * -77 = -2849
    run_op(8'h25, 8'hB3, 1'b1, 16'hF4DF, 8'hE9);

    // Start held high with operands changing every cycle
    for (int j = 0; j < 27; j++) begin
      ta[j]   = 8'($urandom);
      tb_b[j] = 8'($urandom);
    end
    ta[0]  = 8'h40; tb_b[0]  = 8'h40; s_ep[0] = 16'h1000; s_er[0] = 8'h20;
    ta[9]  = 8'h80; tb_b[9]  = 8'h80; s_ep[1] = 16'h4000; s_er[1] = 8'h7F;
    ta[18] = 8'h60; tb_b[18] = 8'hC0; s_ep[2] = 16'hE800; s_er[2] = 8'hD0;
    ndone = 0;
    for (int j = 0; j <= 30; j++) begin
      if (j > 0) begin
        @(negedge clk);
        if (done) begin
          ndone++;
          check("stream_gap", j, 9 * ndone);
          if (ndone <= 3) begin
            check("stream_prod",   prod,   s_ep[ndone-1]);
            check("stream_result", result, s_er[ndone-1]);
          end
        end
      end
      start = (j <= 26);
      if (j <= 26) begin
        a = ta[j];
        b = tb_b[j];
      end
    end
    check("stream_count", ndone, 3);

    // Reset in RUN cycle 4 clears outputs immediately and aborts the operation
    start = 1'b1;
    a     = 8'h33;
    b     = 8'h55;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 nReset = 1'b0;
    #1;
    check("abort_busy",   busy,   0);
    check("abort_done",   done,   0);
    check("abort_prod",   prod,   0);
    check("abort_result", result, 0);
    repeat (2) @(negedge clk);
    nReset = 1'b1;
    ndone  = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort_no_done", ndone, 0);

    // Fresh reset, then a start on the first edge after release: 127 * 127
    #2 nReset = 1'b0;
    @(negedge clk);
    nReset = 1'b1;
    run_op(8'h7F, 8'h7F, 1'b0, 16'h3F01, 8'h7E);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute bound on run time
  initial begin
    #100000;
    n_fail++;
    $display("FAIL timeout: actual=running required=finished");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mul_seq
`default_nettype wire

// File: doc/mul_seq.md
MUL_SEQ -- requirements
Module: mul_seq

Interface
REQ-001 The module SHALL have parameter n, default 8, meaning the data bus width in bits, equal to the register file width.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-003 nReset  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 start  input  1  SHALL request a multiply of a and b.
REQ-005 a  input  n  SHALL be the signed multiplicand, driven from register-file read port 1.
REQ-006 b  input  n  SHALL be the signed multiplier, driven from register-file read port 2.
REQ-007 busy  output  1  SHALL be high while a multiply is in progress.
REQ-008 done  output  1  SHALL be a one-cycle pulse marking valid results; it also serves as the register-file write enable.
REQ-009 prod  output  2n  SHALL carry the full signed product a*b.
REQ-010 result  output  n  SHALL carry the saturated fractional product, Q1.(n-1), written back to the register file.

Function
REQ-011 FSM states SHALL be IDLE, RUN and DONE.
- IDLE->RUN on start.
- RUN->DONE after exactly n RUN cycles.
- DONE->RUN on start; otherwise DONE->IDLE.
REQ-012 On an accepted start, a and b SHALL be latched at that edge; later changes on a/b SHALL NOT affect the operation.
REQ-013 start SHALL be ignored while in RUN; busy SHALL be high in RUN only.
REQ-014 The datapath SHALL be a radix-2 shift-add using a 2n-bit accumulator, an n-bit multiplier shift register and a counter of clog2(n+1) bits.
- The final step SHALL subtract the partial product for the sign bit of b (two's-complement correction).
REQ-015 Latency: for start accepted at edge t, done SHALL be high for the cycle following edge t+n, and for exactly one cycle.
REQ-016 prod SHALL equal the exact signed product; range [-2^(2n-2)+2^(n-1), 2^(2n-2)].
REQ-017 result SHALL equal prod[2n-2:n-1], i.e. arithmetic shift right by n-1, truncated toward minus infinity.
- Exception: when prod = 2^(2n-2) (only from -2^(n-1) * -2^(n-1)), result SHALL saturate to 2^(n-1)-1.
REQ-018 prod and result SHALL be registered, SHALL change only on the edge entering DONE, and SHALL hold until the next DONE.
REQ-019 Back-to-back: start during DONE SHALL be accepted, and done SHALL pulse again exactly n+1 cycles after the previous done.
REQ-020 Operand 0 on either input SHALL produce prod = 0 and result = 0 with the normal latency; there SHALL be no early termination.

Reset
REQ-021 While nReset is low, the module SHALL hold state IDLE, busy=0, done=0, prod=0, result=0, and the counter and operand registers at 0, regardless of clk.
REQ-022 Reset asserted mid-RUN SHALL abort the operation, and no done pulse SHALL follow deassertion.
REQ-023 A start in the first clock edge after nReset deasserts SHALL be accepted normally.

Structure
REQ-024 The state enum type and the default width constant (8) SHALL reside in the shared package picomips_pkg.
REQ-025 The block SHALL contain no sub-module; the FSM, counter and shift-add datapath SHALL be inline, with saturation as a combinational stage ahead of the output register.

Verification
REQ-026 The bench SHALL cover each of the following directed scenarios (n=8):
- a=0x40, b=0x40, start pulse -> done exactly 9 cycles later; prod=0x1000, result=0x20.
- a=0x80, b=0x80 -> prod=0x4000, result=0x7F (saturated).
- a=0x60, b=0xC0 -> prod=0xE800, result=0xD0; a=0x00, b=0x7F -> prod=0x0000, result=0x00.
- start re-pulsed at RUN cycles 2 and 5 with a, b changed -> ignored; one done; product of the original operands.
- start held high continuously, operand pairs changed each cycle -> done every 9 cycles, each product matching the operands latched at its accept edge.
- nReset low at RUN cycle 4 -> outputs 0 immediately (asynchronously); no done after release; a new start then completes correctly.
